ex_muldiv_stage: RTL and testbench



---
 rtl/ex_muldiv_stage.sv | 180 ++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - MIPS32 execute stage: ALU, shifts, HI/LO, single-cycle multiply, iterative divide
module ex_muldiv_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [OP_W-1:0]   aluOp,
    input  logic [DATA_W-1:0] opNum1,
    input  logic [DATA_W-1:0] opNum2,
    input  logic              writeReg_i,
    input  logic [ADDR_W-1:0] writeAddr_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic              writeReg_o,
    output logic [ADDR_W-1:0] writeAddr_o,
    output logic [DATA_W-1:0] writeData_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [OP_W-1:0] OP_OR    = OP_W'('h01);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'('h02);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'('h03);
    localparam logic [OP_W-1:0] OP_NOR   = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'('h05);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'('h06);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'('h07);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'('h08);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'('h09);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'('h0A);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'('h0B);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'('h0C);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'('h0D);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'('h0E);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'('h0F);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'('h10);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'('h11);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'('h12);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'('h13);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} div_state_t;
    div_state_t state, state_next;

    logic              accept, is_div, is_mul, div_signed;
    logic [SH_W-1:0]   shamt, count;
    logic [DATA_W-1:0] result;
    logic              wr_en;
    logic [2*DATA_W-1:0] mul_a, mul_b, product;

    logic [DATA_W-1:0] dvd_q, dsr_q, rem_q;
    logic              q_neg, r_neg, dz_q;
    logic [DATA_W:0]   shifted, diff;
    logic [DATA_W-1:0] quo_fin, rem_fin;
    logic              dvd_neg, dsr_neg;

    assign busy_o     = (state != S_IDLE);
    assign accept     = valid_i & ~busy_o & ~flush_i & ~rst;
    assign is_div     = (aluOp == OP_DIV) || (aluOp == OP_DIVU);
    assign is_mul     = (aluOp == OP_MULT) || (aluOp == OP_MULTU);
    assign div_signed = (aluOp == OP_DIV);
    assign shamt      = opNum2[SH_W-1:0];

    // Sign-extend for MULT, zero-extend for MULTU; the low 2*DATA_W bits are then exact
    assign mul_a   = (aluOp == OP_MULT) ? {{DATA_W{opNum1[DATA_W-1]}}, opNum1} : {{DATA_W{1'b0}}, opNum1};
    assign mul_b   = (aluOp == OP_MULT) ? {{DATA_W{opNum2[DATA_W-1]}}, opNum2} : {{DATA_W{1'b0}}, opNum2};
    assign product = mul_a * mul_b;

    always_comb begin
        result = '0;
        wr_en  = writeReg_i;
        case (aluOp)
            OP_OR:   result = opNum1 | opNum2;
            OP_AND:  result = opNum1 & opNum2;
            OP_XOR:  result = opNum1 ^ opNum2;
            OP_NOR:  result = ~(opNum1 | opNum2);
            OP_ADD:  result = opNum1 + opNum2;
            OP_SUB:  result = opNum1 - opNum2;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(opNum1) < $signed(opNum2))};
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, (opNum1 < opNum2)};
            OP_SLL:  result = opNum1 << shamt;
            OP_SRL:  result = opNum1 >> shamt;
            OP_SRA:  result = $unsigned($signed(opNum1) >>> shamt);
            OP_MFHI: result = hi_o;
            OP_MFLO: result = lo_o;
            OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: wr_en = 1'b0;
            default: wr_en = 1'b0;
        endcase
    end

    assign dvd_neg = div_signed & opNum1[DATA_W-1];
    assign dsr_neg = div_signed & opNum2[DATA_W-1];

    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits
    assign shifted = {rem_q, dvd_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, dsr_q};
    assign quo_fin = dz_q ? '1 : (q_neg ? -dvd_q : dvd_q);
    assign rem_fin = r_neg ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) state <= S_IDLE;
        else                state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept && is_div) state_next = S_RUN;
            S_RUN:  if (count == SH_W'(DATA_W-1)) state_next = S_FIN;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            dvd_q <= '0;
            dsr_q <= '0;
            rem_q <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            dz_q  <= 1'b0;
        end else if (state == S_IDLE && accept && is_div) begin
            count <= '0;
            dvd_q <= dvd_neg ? -opNum1 : opNum1;
            dsr_q <= dsr_neg ? -opNum2 : opNum2;
            rem_q <= '0;
            q_neg <= dvd_neg ^ dsr_neg;
            r_neg <= dvd_neg;
            dz_q  <= (opNum2 == '0);
        end else if (state == S_RUN) begin
            count <= count + SH_W'(1);
            if (!diff[DATA_W]) begin
                rem_q <= diff[DATA_W-1:0];
                dvd_q <= {dvd_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[DATA_W-1:0];
                dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o     <= 1'b0;
            writeReg_o  <= 1'b0;
            writeAddr_o <= '0;
            writeData_o <= '0;
            hi_o        <= '0;
            lo_o        <= '0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            writeReg_o <= 1'b0;
        end else if (state == S_FIN) begin
            valid_o    <= 1'b1;
            writeReg_o <= 1'b0;
            hi_o       <= rem_fin;
            lo_o       <= quo_fin;
        end else if (accept) begin
            valid_o     <= ~is_div;
            writeReg_o  <= wr_en;
            writeAddr_o <= writeAddr_i;
            writeData_o <= result;
            if (is_mul) begin
                hi_o <= product[2*DATA_W-1:DATA_W];
                lo_o <= product[DATA_W-1:0];
            end
            if (aluOp == OP_MTHI) hi_o <= opNum1;
            if (aluOp == OP_MTLO) lo_o <= opNum1;
        end else begin
            valid_o    <= 1'b0;
            writeReg_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb/tb_ex_muldiv_stage.sv - directed vector bench for ex_muldiv_stage
module tb_ex_muldiv_stage;
    logic        clk = 1'b0;
    logic        rst, flush_i, valid_i, writeReg_i;
    logic [7:0]  aluOp;
    logic [31:0] opNum1, opNum2;
    logic [4:0]  writeAddr_i;
    logic        busy_o, valid_o, writeReg_o;
    logic [4:0]  writeAddr_o;
    logic [31:0] writeData_o, hi_o, lo_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv_stage #(.DATA_W(32), .ADDR_W(5), .OP_W(8)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i),
        .aluOp(aluOp), .opNum1(opNum1), .opNum2(opNum2),
        .writeReg_i(writeReg_i), .writeAddr_i(writeAddr_i),
        .busy_o(busy_o), .valid_o(valid_o), .writeReg_o(writeReg_o),
        .writeAddr_o(writeAddr_o), .writeData_o(writeData_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] exp_data;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic present(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic wr, input logic [4:0] addr);
        aluOp = op; opNum1 = a; opNum2 = b; writeReg_i = wr; writeAddr_i = addr;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy_o && c < 100) begin
            step();
            c++;
        end
        if (busy_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: busy_o still 1 after %0d cycles, required 0", name, c);
        end
    endtask

    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        present(op, a, b, 1'b1, 5'd9);
        check({name, "_accept_valid"}, valid_o, 0);
        wait_idle(name);
        check({name, "_done_valid"}, valid_o, 1);
        check({name, "_done_wr"}, writeReg_o, 0);
        check({name, "_lo"}, lo_o, exp_lo);
        check({name, "_hi"}, hi_o, exp_hi);
    endtask

    initial begin
        int cnt;
        logic seen_valid;

        vecs[0]  = '{8'h01, 32'h0000F0F0, 32'h00000F0F, 1'b1, 5'd5,  32'h0000FFFF, 1'b1};
        vecs[1]  = '{8'h02, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 5'd6,  32'h0F000F00, 1'b1};
        vecs[2]  = '{8'h03, 32'hAAAA5555, 32'hFFFF0000, 1'b1, 5'd7,  32'h55555555, 1'b1};
        vecs[3]  = '{8'h04, 32'h0F0F0000, 32'h00000F0F, 1'b1, 5'd8,  32'hF0F0F0F0, 1'b1};
        vecs[4]  = '{8'h05, 32'h7FFFFFFF, 32'h00000001, 1'b1, 5'd9,  32'h80000000, 1'b1};
        vecs[5]  = '{8'h06, 32'h00000000, 32'h00000001, 1'b1, 5'd10, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{8'h07, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd11, 32'h00000001, 1'b1};
        vecs[7]  = '{8'h08, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd12, 32'h00000000, 1'b1};
        vecs[8]  = '{8'h09, 32'h00000001, 32'h0000003F, 1'b1, 5'd13, 32'h80000000, 1'b1};
        vecs[9]  = '{8'h0A, 32'h80000000, 32'h00000004, 1'b1, 5'd14, 32'h08000000, 1'b1};
        vecs[10] = '{8'h0B, 32'h80000000, 32'h00000004, 1'b1, 5'd15, 32'hF8000000, 1'b1};
        vecs[11] = '{8'h55, 32'h12345678, 32'h11111111, 1'b1, 5'd16, 32'h00000000, 1'b0};
        vecs[12] = '{8'h05, 32'h00000002, 32'h00000003, 1'b0, 5'd17, 32'h00000005, 1'b0};
        vecs[13] = '{8'h07, 32'h00000001, 32'hFFFFFFFF, 1'b1, 5'd18, 32'h00000000, 1'b1};

        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; writeReg_i = 1'b0;
        aluOp = '0; opNum1 = '0; opNum2 = '0; writeAddr_i = '0;
        step();
        step();
        check("rst_valid", valid_o, 0);
        check("rst_wr", writeReg_o, 0);
        check("rst_addr", writeAddr_o, 0);
        check("rst_data", writeData_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_busy", busy_o, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 14; i++) begin
            present(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wr, vecs[i].addr);
            check($sformatf("vec%0d_valid", i), valid_o, 1);
            check($sformatf("vec%0d_data", i), writeData_o, vecs[i].exp_data);
            check($sformatf("vec%0d_wr", i), writeReg_o, vecs[i].exp_wr);
            check($sformatf("vec%0d_addr", i), writeAddr_o, vecs[i].addr);
        end
        step();
        check("idle_valid", valid_o, 0);

        present(8'h10, 32'hFFFFFFFE, 32'h00000003, 1'b1, 5'd4);
        check("mult_hi", hi_o, 32'hFFFFFFFF);
        check("mult_lo", lo_o, 32'hFFFFFFFA);
        check("mult_wr", writeReg_o, 0);
        present(8'h0D, 32'h0, 32'h0, 1'b1, 5'd7);
        check("mflo_data", writeData_o, 32'hFFFFFFFA);
        check("mflo_wr", writeReg_o, 1);
        check("mflo_addr", writeAddr_o, 7);
        present(8'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd4);
        check("multu_hi", hi_o, 32'hFFFFFFFE);
        check("multu_lo", lo_o, 32'h00000001);
        present(8'h0C, 32'h0, 32'h0, 1'b1, 5'd8);
        check("mfhi_data", writeData_o, 32'hFFFFFFFE);

        // DIV -7/2 with an ADD held on the inputs the whole time
        present(8'h12, 32'hFFFFFFF9, 32'h00000002, 1'b1, 5'd2);
        check("div_accept_valid", valid_o, 0);
        aluOp = 8'h05; opNum1 = 32'd10; opNum2 = 32'd20; writeReg_i = 1'b1; writeAddr_i = 5'd3;
        valid_i = 1'b1;
        cnt = 0;
        seen_valid = 1'b0;
        while (busy_o && cnt < 100) begin
            cnt++;
            if (valid_o) seen_valid = 1'b1;
            step();
        end
        check("div_busy_cycles", cnt, 33);
        check("div_no_valid_while_busy", seen_valid, 0);
        check("div_done_valid", valid_o, 1);
        check("div_done_wr", writeReg_o, 0);
        check("div_lo", lo_o, 32'hFFFFFFFD);
        check("div_hi", hi_o, 32'hFFFFFFFF);
        step();
        valid_i = 1'b0;
        check("held_add_valid", valid_o, 1);
        check("held_add_data", writeData_o, 32'd30);
        check("held_add_wr", writeReg_o, 1);
        check("held_add_addr", writeAddr_o, 3);

        run_div("divu_by0", 8'h13, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
        run_div("div_minneg", 8'h12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
        run_div("div_neg_by0", 8'h12, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF8);
        run_div("divu_100_7", 8'h13, 32'd100, 32'd7, 32'd14, 32'd2);

        present(8'h0E, 32'h00001234, 32'h0, 1'b1, 5'd1);
        check("mthi_hi", hi_o, 32'h1234);
        check("mthi_wr", writeReg_o, 0);
        present(8'h0F, 32'h00001234, 32'h0, 1'b1, 5'd1);
        check("mtlo_lo", lo_o, 32'h1234);

        // Flush on the 10th RUN cycle
        present(8'h13, 32'd100, 32'd7, 1'b1, 5'd1);
        for (int i = 0; i < 9; i++) step();
        check("flush_pre_busy", busy_o, 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_busy", busy_o, 0);
        check("flush_valid", valid_o, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen_valid = 1'b1;
            step();
        end
        check("flush_no_pulse", seen_valid, 0);
        check("flush_hi", hi_o, 32'h1234);
        check("flush_lo", lo_o, 32'h1234);

        // Flush landing on the FIN cycle
        present(8'h13, 32'd100, 32'd7, 1'b1, 5'd1);
        for (int i = 0; i < 32; i++) step();
        check("fin_pre_busy", busy_o, 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("fin_flush_busy", busy_o, 0);
        check("fin_flush_valid", valid_o, 0);
        check("fin_flush_hi", hi_o, 32'h1234);
        check("fin_flush_lo", lo_o, 32'h1234);

        // Flush beats a simultaneous valid_i
        flush_i = 1'b1;
        present(8'h05, 32'd1, 32'd1, 1'b1, 5'd1);
        flush_i = 1'b0;
        check("flush_blocks_accept", valid_o, 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_hi", hi_o, 0);
        check("rst2_lo", lo_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
